// File: rtl/bk_pkg.sv
// Shared types and constants for the backup-RAM sequencer and its autosave timer.
package bk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_ACK,
        ST_XFER,
        ST_NEXT
    } bk_state_t;

    typedef enum logic {
        DIR_LOAD = 1'b0,
        DIR_SAVE = 1'b1
    } bk_dir_t;

    localparam int SECTOR_BYTES = 512;
    localparam int SECTOR_SHIFT = $clog2(SECTOR_BYTES);

    // Index of the last sector covered by a BSRAM byte mask.
    function automatic logic [14:0] last_sector(input logic [23:0] ram_mask);
        return ram_mask[23:SECTOR_SHIFT];
    endfunction

endpackage

// File: rtl/bk_autosave_timer.sv
// Dirty flag plus idle countdown; raises expire once the BSRAM has been quiet
// for AUTOSAVE_DLY cycles while the sequencer sits idle. Only used when
// BK_AUTOSAVE_EN is defined.
module bk_autosave_timer #(
    parameter logic [31:0] AUTOSAVE_DLY = 32'd107_000_000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic bsram_wr,
    input  logic bk_loading,
    input  logic idle,
    input  logic clear,
    output logic expire
);

    logic        dirty_q, dirty_d;
    logic [31:0] cnt_q, cnt_d;

    // Core writes (outside loads) mark the RAM dirty and restart the quiet period; a write wins over a same-cycle clear.
    always_comb begin
        dirty_d = dirty_q;
        cnt_d   = cnt_q;
        if (idle && (cnt_q != 32'd0)) begin
            cnt_d = cnt_q - 32'd1;
        end
        if (clear) begin
            dirty_d = 1'b0;
        end
        if (bsram_wr && !bk_loading) begin
            dirty_d = 1'b1;
            cnt_d   = AUTOSAVE_DLY;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            dirty_q <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            dirty_q <= dirty_d;
            cnt_q   <= cnt_d;
        end
    end

    assign expire = idle && dirty_q && (cnt_q == 32'd1);

endmodule

// File: rtl/bk_sequencer.sv
// Backup-RAM sector transfer sequencer between BSRAM and the HPS SD interface.
// Optional idle-timed autosave is built in when BK_AUTOSAVE_EN is defined.
module bk_sequencer
    import bk_pkg::*;
#(
    parameter int          LBA_W        = 32,
    parameter logic [31:0] AUTOSAVE_DLY = 32'd107_000_000,
    parameter logic [31:0] ACK_TMO      = 32'd21_000_000
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [23:0]      ram_mask,
    input  logic             bk_ena,
    input  logic             dl_done,
    input  logic             load_req,
    input  logic             save_req,
    input  logic             bsram_wr,
    input  logic             sd_ack,
    output logic [LBA_W-1:0] sd_lba,
    output logic             sd_rd,
    output logic             sd_wr,
    output logic             bk_loading,
    output logic             bk_busy,
    output logic             bk_err
);

    bk_state_t        state_q, state_d;
    bk_dir_t          dir_q, dir_d;
    logic             start_pend_q, start_pend_d;
    logic             load_req_q, save_req_q;
    logic             ack_q1, ack_q2;
    logic [31:0]      ack_cnt_q, ack_cnt_d;
    logic [LBA_W-1:0] lba_q, lba_d;
    logic             rd_q, rd_d, wr_q, wr_d;
    logic             loading_q, loading_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic             load_rise, save_rise, ack_rise, ack_fall;
    logic             start_ok, any_event, load_done, autosave_expire;
    bk_dir_t          start_dir;
    logic [LBA_W-1:0] last_lba;

    assign load_rise = load_req & ~load_req_q;
    assign save_rise = save_req & ~save_req_q;
    assign ack_rise  = ack_q1 & ~ack_q2;
    assign ack_fall  = ~ack_q1 & ack_q2;
    assign last_lba  = LBA_W'(last_sector(ram_mask));
    assign start_ok  = (state_q == ST_IDLE) && !start_pend_q && bk_ena && (ram_mask != 24'd0);
    assign any_event = dl_done | load_rise | save_rise | autosave_expire;
    assign start_dir = (dl_done || load_rise) ? DIR_LOAD : DIR_SAVE;

`ifdef BK_AUTOSAVE_EN
    logic dirty_clr;

    assign dirty_clr = dl_done | load_done
                     | (start_ok & ~dl_done & ~load_rise & ~save_rise & autosave_expire);

    bk_autosave_timer #(
        .AUTOSAVE_DLY (AUTOSAVE_DLY)
    ) u_autosave (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .bsram_wr   (bsram_wr),
        .bk_loading (loading_q),
        .idle       (state_q == ST_IDLE),
        .clear      (dirty_clr),
        .expire     (autosave_expire)
    );
`else
    logic unused_cfg;

    assign autosave_expire = 1'b0;
    assign unused_cfg      = &{1'b0, bsram_wr, AUTOSAVE_DLY, load_done};
`endif

    // Next-state logic: an accepted start is held one cycle in start_pend, then the FSM walks sectors 0..last with a request/ack handshake each.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        start_pend_d = 1'b0;
        ack_cnt_d    = ack_cnt_q;
        lba_d        = lba_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        loading_d    = loading_q;
        busy_d       = busy_q;
        err_d        = err_q;
        load_done    = 1'b0;

        if (start_ok && any_event) begin
            start_pend_d = 1'b1;
            dir_d        = start_dir;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_pend_q) begin
                    state_d   = ST_REQ;
                    lba_d     = '0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    loading_d = (dir_q == DIR_LOAD);
                    rd_d      = (dir_q == DIR_LOAD);
                    wr_d      = (dir_q == DIR_SAVE);
                end
            end
            ST_REQ: begin
                state_d   = ST_WAIT_ACK;
                ack_cnt_d = 32'd0;
            end
            ST_WAIT_ACK: begin
                if (ack_rise) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = ST_XFER;
                end else if (ack_cnt_q >= ACK_TMO) begin
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    loading_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 32'd1;
                end
            end
            ST_XFER: begin
                if (ack_fall) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (lba_q >= last_lba) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    loading_d = 1'b0;
                    load_done = (dir_q == DIR_LOAD);
                end else begin
                    state_d = ST_REQ;
                    lba_d   = lba_q + LBA_W'(1);
                    rd_d    = (dir_q == DIR_LOAD);
                    wr_d    = (dir_q == DIR_SAVE);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state and outputs registered; the request edge and ack sync registers run every cycle, even mid-transfer.
    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_LOAD;
            start_pend_q <= 1'b0;
            load_req_q   <= 1'b0;
            save_req_q   <= 1'b0;
            ack_q1       <= 1'b0;
            ack_q2       <= 1'b0;
            ack_cnt_q    <= 32'd0;
            lba_q        <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            loading_q    <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            start_pend_q <= start_pend_d;
            load_req_q   <= load_req;
            save_req_q   <= save_req;
            ack_q1       <= sd_ack;
            ack_q2       <= ack_q1;
            ack_cnt_q    <= ack_cnt_d;
            lba_q        <= lba_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            loading_q    <= loading_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign sd_lba     = lba_q;
    assign sd_rd      = rd_q;
    assign sd_wr      = wr_q;
    assign bk_loading = loading_q;
    assign bk_busy    = busy_q;
    assign bk_err     = err_q;

endmodule

// File: tb/tb_bk_sequencer.sv
// Self-checking bench for bk_sequencer: a vector table for reset and the first
// save sector, then hand-written sequences for multi-sector, priority, timeout,
// reset-abort and autosave (BK_AUTOSAVE_EN) behaviour.
module tb_bk_sequencer;

    localparam int          LBA_W   = 32;
    localparam logic [31:0] ASV_DLY = 32'd100;
    localparam logic [31:0] ACK_TMO = 32'd20;

    logic             clk_sys = 1'b0;
    logic             reset;
    logic [23:0]      ram_mask;
    logic             bk_ena, dl_done, load_req, save_req, bsram_wr, sd_ack;
    logic [LBA_W-1:0] sd_lba;
    logic             sd_rd, sd_wr, bk_loading, bk_busy, bk_err;

    int n_vec  = 0;
    int n_miss = 0;
    bit mon_load = 1'b0;
    bit wr_in_load = 1'b0;

    typedef struct {
        logic             rst_n, dl, ld, sv, ack;
        logic [LBA_W-1:0] exp_lba;
        logic             exp_rd, exp_wr, exp_loading, exp_busy, exp_err;
    } vec_t;

    vec_t vecs[11];

    bk_sequencer #(
        .LBA_W        (LBA_W),
        .AUTOSAVE_DLY (ASV_DLY),
        .ACK_TMO      (ACK_TMO)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ram_mask   (ram_mask),
        .bk_ena     (bk_ena),
        .dl_done    (dl_done),
        .load_req   (load_req),
        .save_req   (save_req),
        .bsram_wr   (bsram_wr),
        .sd_ack     (sd_ack),
        .sd_lba     (sd_lba),
        .sd_rd      (sd_rd),
        .sd_wr      (sd_wr),
        .bk_loading (bk_loading),
        .bk_busy    (bk_busy),
        .bk_err     (bk_err)
    );

    always #5 clk_sys = ~clk_sys;

    // Hard stop in case a sequence stalls.
    initial begin
        #400_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and land on the following falling edge to sample.
    task automatic tick();
        @(posedge clk_sys);
        @(negedge clk_sys);
        if (mon_load && sd_wr === 1'b1) wr_in_load = 1'b1;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        reset    = v.rst_n;
        dl_done  = v.dl;
        load_req = v.ld;
        save_req = v.sv;
        sd_ack   = v.ack;
    endtask

    // Serve one sector whose request is currently high, checking handshake timing.
    task automatic serve_sector(input logic [LBA_W-1:0] exp_lba, input bit is_wr,
                                input bit is_last, input bit exp_ld);
        check_output("lba", sd_lba, exp_lba);
        check_output("req_up", is_wr ? sd_wr : sd_rd, 1);
        check_output("other_req", is_wr ? sd_rd : sd_wr, 0);
        check_output("loading", bk_loading, exp_ld);
        sd_ack = 1'b1;
        tick();
        check_output("req_hold", is_wr ? sd_wr : sd_rd, 1);
        tick();
        check_output("req_drop2", is_wr ? sd_wr : sd_rd, 0);
        tick();
        sd_ack = 1'b0;
        tick();
        check_output("req_low_f1", is_wr ? sd_wr : sd_rd, 0);
        tick();
        check_output("req_low_f2", is_wr ? sd_wr : sd_rd, 0);
        tick();
        if (is_last) begin
            check_output("done_busy", bk_busy, 0);
            check_output("done_loading", bk_loading, 0);
            check_output("done_req", {sd_rd, sd_wr}, 0);
        end else begin
            check_output("next_req3", is_wr ? sd_wr : sd_rd, 1);
            check_output("next_lba", sd_lba, exp_lba + 1);
        end
    endtask

    initial begin
        int cnt;
        bit seen;

        reset = 1'b0; ram_mask = 24'h7FF; bk_ena = 1'b1;
        dl_done = 1'b0; load_req = 1'b0; save_req = 1'b0; bsram_wr = 1'b0; sd_ack = 1'b0;

        // {rst_n, dl, ld, sv, ack, lba, rd, wr, loading, busy, err}
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        @(negedge clk_sys);

        // Reset state and first save sector (mask 7FF -> 4 sectors).
        $display("[TB] vector table: reset and first save sector");
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i]);
            tick();
            check_output($sformatf("vec%0d_lba", i), sd_lba, vecs[i].exp_lba);
            check_output($sformatf("vec%0d_rd", i), sd_rd, vecs[i].exp_rd);
            check_output($sformatf("vec%0d_wr", i), sd_wr, vecs[i].exp_wr);
            check_output($sformatf("vec%0d_loading", i), bk_loading, vecs[i].exp_loading);
            check_output($sformatf("vec%0d_busy", i), bk_busy, vecs[i].exp_busy);
            check_output($sformatf("vec%0d_err", i), bk_err, vecs[i].exp_err);
        end
        for (int s = 1; s < 4; s++) serve_sector(s, 1'b1, s == 3, 1'b0);
        save_req = 1'b0;
        tick();

        // dl_done load of 16 sectors.
        $display("[TB] dl_done load, 16 sectors");
        ram_mask = 24'h1FFF;
        mon_load = 1'b1;
        dl_done = 1'b1;
        tick();
        dl_done = 1'b0;
        check_output("load_pending_rd", sd_rd, 0);
        tick();
        check_output("load_busy", bk_busy, 1);
        for (int s = 0; s < 16; s++) serve_sector(s, 1'b0, s == 15, 1'b1);
        mon_load = 1'b0;
        check_output("no_wr_in_load", wr_in_load, 0);

        // Simultaneous load/save edges: load wins, mid-load save edge ignored.
        $display("[TB] priority and busy-ignore");
        ram_mask = 24'h7FF;
        load_req = 1'b1; save_req = 1'b1;
        tick();
        tick();
        check_output("prio_rd", sd_rd, 1);
        check_output("prio_wr", sd_wr, 0);
        check_output("prio_loading", bk_loading, 1);
        serve_sector(0, 1'b0, 1'b0, 1'b1);
        save_req = 1'b0;
        serve_sector(1, 1'b0, 1'b0, 1'b1);
        save_req = 1'b1;
        serve_sector(2, 1'b0, 1'b0, 1'b1);
        serve_sector(3, 1'b0, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bk_busy || sd_rd || sd_wr) seen = 1'b1;
        end
        check_output("no_retrigger", seen, 0);
        load_req = 1'b0; save_req = 1'b0;
        tick();

        // Ack timeout.
        $display("[TB] ack timeout");
        save_req = 1'b1;
        tick();
        tick();
        check_output("tmo_wr_up", sd_wr, 1);
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (sd_wr) cnt++;
            else break;
        end
        check_output("tmo_wr_cycles", cnt, ACK_TMO + 2);
        check_output("tmo_err", bk_err, 1);
        check_output("tmo_busy", bk_busy, 0);
        check_output("tmo_wr_low", sd_wr, 0);
        save_req = 1'b0;
        tick();
        save_req = 1'b1;
        tick();
        check_output("err_held_pending", bk_err, 1);
        tick();
        check_output("err_cleared", bk_err, 0);
        for (int s = 0; s < 4; s++) serve_sector(s, 1'b1, s == 3, 1'b0);
        save_req = 1'b0;
        tick();

        // Start gating: empty mask or no save file.
        $display("[TB] start gating");
        ram_mask = 24'h0;
        save_req = 1'b1;
        tick(); tick(); tick();
        check_output("mask0_busy", bk_busy, 0);
        save_req = 1'b0;
        ram_mask = 24'h7FF;
        bk_ena = 1'b0;
        tick();
        load_req = 1'b1;
        tick(); tick(); tick();
        check_output("ena0_busy", bk_busy, 0);
        load_req = 1'b0;
        bk_ena = 1'b1;
        tick();

        // Reset at sector 5 of a 16-sector load.
        $display("[TB] reset mid-load");
        ram_mask = 24'h1FFF;
        dl_done = 1'b1;
        tick();
        dl_done = 1'b0;
        tick();
        for (int s = 0; s < 5; s++) serve_sector(s, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        tick();
        check_output("rst_lba", sd_lba, 0);
        check_output("rst_req", {sd_rd, sd_wr}, 0);
        check_output("rst_flags", {bk_loading, bk_busy, bk_err}, 0);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bk_busy || sd_rd || sd_wr) seen = 1'b1;
        end
        check_output("rst_no_req", seen, 0);

        ram_mask = 24'h7FF;
`ifdef BK_AUTOSAVE_EN
        // Autosave: writes at t=0 and t=50, save request 101 cycles after the second.
        $display("[TB] autosave");
        bsram_wr = 1'b1;
        tick();
        bsram_wr = 1'b0;
        for (int i = 0; i < 49; i++) tick();
        bsram_wr = 1'b1;
        tick();
        bsram_wr = 1'b0;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            cnt++;
            if (sd_wr) break;
        end
        check_output("asv_delay", cnt, 101);
        for (int s = 0; s < 4; s++) serve_sector(s, 1'b1, s == 3, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (bk_busy) seen = 1'b1;
        end
        check_output("asv_once", seen, 0);
        bk_ena = 1'b0;
        bsram_wr = 1'b1;
        tick();
        bsram_wr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (bk_busy || sd_wr) seen = 1'b1;
        end
        check_output("asv_ena0", seen, 0);
        bk_ena = 1'b1;
`else
        // Without autosave, BSRAM writes never start a transfer.
        $display("[TB] bsram_wr without autosave");
        bsram_wr = 1'b1;
        tick();
        bsram_wr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bk_busy || sd_wr) seen = 1'b1;
        end
        check_output("no_autosave", seen, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
